// File: rtl/cswap_pkg.sv
// cswap_pkg: shared constants, group-count helper and stage-1 payload type for cla_cmp_swap.
package cswap_pkg;
    localparam int GRP_W = 4;
    localparam int MAX_W = 32;
    localparam int MAX_GRP = MAX_W / GRP_W;

    function automatic int ngrp(input int width);
        return width / GRP_W;
    endfunction

    typedef struct packed {
        logic [MAX_W-1:0]   a;
        logic [MAX_W-1:0]   b;
        logic [MAX_GRP-1:0] grp_g;
        logic [MAX_GRP-1:0] grp_p;
        logic               valid;
    } s1_t;
endpackage

// File: rtl/cla_pg_group4.sv
// cla_pg_group4: 4-bit group generate/propagate for A + ~B (subtraction) lookahead.
module cla_pg_group4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       grp_g,
    output logic       grp_p
);
    logic [3:0] g, p;
    assign g = a & ~b;
    assign p = a ^ ~b;
    assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign grp_p = &p;
endmodule

// File: rtl/cla_cmp_swap.sv
// cla_cmp_swap: 2-stage CLA compare-and-swap with ready/valid; define CSWAP_STATS_EN for the swap_count port.
module cla_cmp_swap
    import cswap_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_min,
    output logic [WIDTH-1:0] out_max,
    output logic             out_swapped,
    output logic             out_equal
`ifdef CSWAP_STATS_EN
    ,
    output logic [15:0]      swap_count
`endif
);
    localparam int NGRP = ngrp(WIDTH);

    logic             en;
    logic [NGRP-1:0]  grp_g, grp_p;
    s1_t              s1_d, s1_q;
    logic [WIDTH-1:0] a_s1, b_s1;
    logic [NGRP-1:0]  g_s1, p_s1;
    logic             cout, equal, gt;
    logic             s2_valid_d, s2_valid_q;
    logic [WIDTH-1:0] out_min_d, out_min_q, out_max_d, out_max_q;
    logic             out_swapped_d, out_swapped_q, out_equal_d, out_equal_q;

    assign en = ~s2_valid_q | out_ready;
    assign in_ready = en;

    for (genvar i = 0; i < NGRP; i++) begin : g_grp
        cla_pg_group4 u_pg (
            .a     (in_a[GRP_W*i +: GRP_W]),
            .b     (in_b[GRP_W*i +: GRP_W]),
            .grp_g (grp_g[i]),
            .grp_p (grp_p[i])
        );
    end

    always_comb begin
        s1_d = s1_q;
        if (en) begin
            s1_d = '0;
            s1_d.a[WIDTH-1:0] = in_a;
            s1_d.b[WIDTH-1:0] = in_b;
            s1_d.grp_g[NGRP-1:0] = grp_g;
            s1_d.grp_p[NGRP-1:0] = grp_p;
            s1_d.valid = in_valid;
        end
    end

    assign a_s1 = s1_q.a[WIDTH-1:0];
    assign b_s1 = s1_q.b[WIDTH-1:0];
    assign g_s1 = s1_q.grp_g[NGRP-1:0];
    assign p_s1 = s1_q.grp_p[NGRP-1:0];

    // Payload slots above WIDTH are always zero in narrower builds.
    if (WIDTH < MAX_W) begin : g_pad
        logic pad_unused;
        assign pad_unused = ^{s1_q.a[MAX_W-1:WIDTH], s1_q.b[MAX_W-1:WIDTH],
                              s1_q.grp_g[MAX_GRP-1:NGRP], s1_q.grp_p[MAX_GRP-1:NGRP]};
    end

    always_comb begin
        cout = 1'b1;
        for (int i = 0; i < NGRP; i++) cout = g_s1[i] | (p_s1[i] & cout);
        equal = &p_s1;
        gt = cout & ~equal;
        s2_valid_d = en ? s1_q.valid : s2_valid_q;
        out_min_d = en ? (gt ? b_s1 : a_s1) : out_min_q;
        out_max_d = en ? (gt ? a_s1 : b_s1) : out_max_q;
        out_swapped_d = en ? gt : out_swapped_q;
        out_equal_d = en ? equal : out_equal_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_valid_q <= 1'b0;
            out_min_q <= '0;
            out_max_q <= '0;
            out_swapped_q <= 1'b0;
            out_equal_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_valid_q <= s2_valid_d;
            out_min_q <= out_min_d;
            out_max_q <= out_max_d;
            out_swapped_q <= out_swapped_d;
            out_equal_q <= out_equal_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_min = out_min_q;
    assign out_max = out_max_q;
    assign out_swapped = out_swapped_q;
    assign out_equal = out_equal_q;

`ifdef CSWAP_STATS_EN
    logic [15:0] swap_count_d, swap_count_q;

    always_comb begin
        swap_count_d = (s2_valid_q & out_ready & out_swapped_q & ~&swap_count_q) ? swap_count_q + 16'd1 : swap_count_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) swap_count_q <= '0;
        else swap_count_q <= swap_count_d;
    end

    assign swap_count = swap_count_q;
`endif
endmodule

// File: tb/tb_cla_cmp_swap.sv
// tb_cla_cmp_swap: directed table plus streaming/backpressure sequences for cla_cmp_swap.
module tb_cla_cmp_swap;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_min, out_max;
    logic         out_swapped, out_equal;
`ifdef CSWAP_STATS_EN
    logic [15:0]  swap_count;
`endif

    always #5 clk = ~clk;

    cla_cmp_swap #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_min     (out_min),
        .out_max     (out_max),
        .out_swapped (out_swapped),
        .out_equal   (out_equal)
`ifdef CSWAP_STATS_EN
        ,
        .swap_count  (swap_count)
`endif
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] mn;
        logic [W-1:0] mx;
        logic         sw;
        logic         eq;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;
    logic [W-1:0] pa [100];
    logic [W-1:0] pb [100];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        vec_t v;
        v.a = a;
        v.b = b;
        v.sw = a > b;
        v.eq = a == b;
        v.mn = (a > b) ? b : a;
        v.mx = (a > b) ? a : b;
        return v;
    endfunction

    function automatic logic [63:0] outs();
        return 64'({out_min, out_max, out_swapped, out_equal});
    endfunction

    function automatic logic [63:0] pack(input vec_t v);
        return 64'({v.mn, v.mx, v.sw, v.eq});
    endfunction

    task automatic run_stream(input int n, input int st_lo, input int st_hi, input bit chk_timing);
        vec_t q[$];
        vec_t e;
        int sent = 0;
        int recv = 0;
        logic [63:0] held = '0;
        bit was_stall = 0;
        for (int c = 0; c < n + 40 && recv < n; c++) begin
            @(negedge clk);
            in_valid = sent < n;
            in_a = (sent < n) ? pa[sent] : '0;
            in_b = (sent < n) ? pb[sent] : '0;
            out_ready = !(c >= st_lo && c <= st_hi);
            #1;
            if (out_valid && !out_ready) begin
                check("stall_in_ready", 64'(in_ready), 64'd0);
                if (was_stall) check("stall_hold", outs(), held);
                held = outs();
                was_stall = 1;
            end else begin
                was_stall = 0;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_result", 64'(recv), 64'(n + 1));
                end else begin
                    e = q.pop_front();
                    check($sformatf("stream_data[%0d]", recv), outs(), pack(e));
                    if (chk_timing) check($sformatf("stream_cycle[%0d]", recv), 64'(c), 64'(recv + 2));
                end
                recv++;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(in_a, in_b));
                sent++;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("stream_count", 64'(recv), 64'(n));
    endtask

    vec_t tbl [10];

    initial begin
        tbl[0] = '{16'h1234, 16'h0FFF, 16'h0FFF, 16'h1234, 1'b1, 1'b0};
        tbl[1] = '{16'h00FF, 16'h0100, 16'h00FF, 16'h0100, 1'b0, 1'b0};
        tbl[2] = '{16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 1'b1, 1'b0};
        tbl[3] = '{16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b0, 1'b0};
        tbl[4] = '{16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hA5A5, 1'b0, 1'b1};
        tbl[5] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1};
        tbl[6] = '{16'h8000, 16'h7FFF, 16'h7FFF, 16'h8000, 1'b1, 1'b0};
        tbl[7] = '{16'h0001, 16'h0000, 16'h0000, 16'h0001, 1'b1, 1'b0};
        tbl[8] = '{16'h1000, 16'h1001, 16'h1000, 16'h1001, 1'b0, 1'b0};
        tbl[9] = '{16'hF000, 16'h0FFF, 16'h0FFF, 16'hF000, 1'b1, 1'b0};

        // reset held with a pair offered
        in_valid = 1'b1;
        in_a = 16'h1234;
        in_b = 16'h0FFF;
        repeat (3) @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_outputs", outs(), 64'd0);
`ifdef CSWAP_STATS_EN
        check("reset_swap_count", 64'(swap_count), 64'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("post_reset_lat1", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("post_reset_lat2", 64'(out_valid), 64'd1);
        check("post_reset_data", outs(), pack(tbl[0]));
        @(negedge clk);
        check("post_reset_drain", 64'(out_valid), 64'd0);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a = tbl[i].a;
            in_b = tbl[i].b;
            @(negedge clk);
            in_valid = 1'b0;
            check($sformatf("vec%0d_early", i), 64'(out_valid), 64'd0);
            @(negedge clk);
            check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("vec%0d_data", i), outs(), pack(tbl[i]));
        end

        // in-flight data discarded by reset
        @(negedge clk);
        in_valid = 1'b1;
        in_a = 16'h4444;
        in_b = 16'h3333;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("flush_valid0", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("flush_valid1", 64'(out_valid), 64'd0);
        check("flush_outputs", outs(), 64'd0);

        for (int i = 0; i < 6; i++) begin
            pa[i] = W'($urandom);
            pb[i] = W'($urandom);
        end
        pa[1] = 16'h7777;
        pb[1] = 16'h7777;
        run_stream(6, 3, 6, 0);

        repeat (3) @(negedge clk);
        for (int i = 0; i < 100; i++) begin
            pa[i] = W'($urandom);
            pb[i] = W'($urandom);
        end
        run_stream(100, 1000, 1000, 1);

`ifdef CSWAP_STATS_EN
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            pa[i] = W'(i + 10);
            pb[i] = (i < 7) ? 16'h0000 : 16'hFFFF;
        end
        run_stream(10, 4, 5, 0);
        repeat (3) @(negedge clk);
        check("swap_count_7", 64'(swap_count), 64'd7);

        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1;
        in_a = 16'h0001;
        in_b = 16'h0000;
        out_ready = 1'b1;
        repeat (65540) @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("swap_count_sat", 64'(swap_count), 64'hFFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
